jtopl_cpuif: RTL and testbench



---
 rtl/jtopl_pkg.sv | 15 +
 rtl/jtopl_fifo.sv | 53 +++++
 rtl/jtopl_cpuif.sv | 146 ++++++++++++++
 tb/tb_jtopl_cpuif.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// Shared constants and types for the OPL host-bus front end.
package jtopl_pkg;

    localparam int BUSY_ADDR_DEF = 12;
    localparam int BUSY_DATA_DEF = 84;

    // Fixed low nibble of the status byte, between the timer flags and busy.
    localparam logic [3:0] STATUS_LOW = 4'b0011;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/jtopl_fifo.sv
// Generic synchronous FIFO with show-ahead output and an occupancy counter.
module jtopl_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jtopl_cpuif.sv
// Host-bus front end: edge-detected writes, bank-aware FIFO, cenop-paced
// register-write strobe, busy-time model and status byte.
module jtopl_cpuif
    import jtopl_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BANKS     = 1,
    parameter int BUSY_ADDR = BUSY_ADDR_DEF,
    parameter int BUSY_DATA = BUSY_DATA_DEF,
    parameter int PACE      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       irq_n,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ovf,
    output logic       reg_we,
    output logic       reg_bank,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_din
);

    localparam int BMAX = (BUSY_DATA > BUSY_ADDR) ? BUSY_DATA : BUSY_ADDR;
    localparam int CW   = (BMAX > 1) ? $clog2(BMAX + 1) : 1;
    localparam int SW   = (PACE > 1) ? $clog2(PACE) : 1;

    logic          wr;
    logic          wr_l;
    logic          ev_addr;
    logic          ev_data;
    logic          bank_sel;
    logic [7:0]    idx;
    logic          bank;
    logic [CW-1:0] busy_cnt;
    logic [SW-1:0] space;
    logic [SW-1:0] space_nx;
    logic          we_nx;
    logic          pop;
    logic [16:0]   fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    drain_state_t  state;
    drain_state_t  state_nx;

    // Only the falling edge of the combined strobe counts as a write.
    assign wr       = ~cs_n & ~wr_n;
    assign ev_addr  = wr & ~wr_l & ~addr[0];
    assign ev_data  = wr & ~wr_l &  addr[0];
    assign bank_sel = (BANKS == 2) ? addr[1] : 1'b0;

    assign busy = (busy_cnt != '0) | fifo_full;
    assign dout = {~irq_n, flag_A, flag_B, STATUS_LOW, busy};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_l     <= 1'b0;
            idx      <= '0;
            bank     <= 1'b0;
            busy_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            wr_l <= wr;
            if (ev_addr) begin
                idx  <= din;
                bank <= bank_sel;
            end
            if (ev_addr)
                busy_cnt <= CW'(BUSY_ADDR);
            else if (ev_data)
                busy_cnt <= CW'(BUSY_DATA);
            else if (cenop && busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
            if (ev_data && fifo_full) ovf <= 1'b1;
        end
    end

    jtopl_fifo #(
        .DW    (17),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_data),
        .pop   (pop),
        .din   ({bank, idx, din}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        we_nx    = reg_we;
        space_nx = space;
        if (cenop && space != '0) space_nx = space - 1'b1;
        case (state)
            ST_IDLE: begin
                if (cenop && !fifo_empty && space == '0) begin
                    pop      = 1'b1;
                    we_nx    = 1'b1;
                    space_nx = SW'(PACE - 1);
                    state_nx = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (cenop) begin
                    we_nx    = 1'b0;
                    state_nx = ST_IDLE;
                    // With no pacing gap the strobe chains straight into the next entry.
                    if (PACE == 1 && !fifo_empty) begin
                        pop      = 1'b1;
                        we_nx    = 1'b1;
                        state_nx = ST_STROBE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            reg_we   <= 1'b0;
            reg_bank <= 1'b0;
            reg_addr <= '0;
            reg_din  <= '0;
            space    <= '0;
        end else begin
            state  <= state_nx;
            reg_we <= we_nx;
            space  <= space_nx;
            if (pop) {reg_bank, reg_addr, reg_din} <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_jtopl_cpuif.sv
// Directed bench for jtopl_cpuif: a DEPTH=4/BANKS=2/PACE=2 instance and a
// DEPTH=8/BANKS=1/PACE=1 instance share the host bus.
module tb_jtopl_cpuif;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cenop = 1'b0;
    logic [7:0] din = '0;
    logic [1:0] addr = '0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       irq_n = 1'b0;
    logic       flag_A = 1'b1;
    logic       flag_B = 1'b0;

    logic [7:0] dout, reg_addr, reg_din;
    logic       busy, ovf, reg_we, reg_bank;
    logic [7:0] dout_p1, reg_addr_p1, reg_din_p1;
    logic       busy_p1, ovf_p1, reg_we_p1, reg_bank_p1;

    int n_tests = 0;
    int n_fail  = 0;
    int cen_div = 0;
    int cen_cnt = 0;
    int tick    = 0;

    logic [16:0] obs_q[$];
    int          obs_t[$];
    logic [16:0] obs_p1_q[$];
    int          obs_p1_t[$];

    jtopl_cpuif #(.DEPTH(4), .BANKS(2), .PACE(2)) u_dut (
        .clk(clk), .rst(rst), .cenop(cenop), .din(din), .addr(addr),
        .cs_n(cs_n), .wr_n(wr_n), .irq_n(irq_n), .flag_A(flag_A), .flag_B(flag_B),
        .dout(dout), .busy(busy), .ovf(ovf), .reg_we(reg_we),
        .reg_bank(reg_bank), .reg_addr(reg_addr), .reg_din(reg_din)
    );

    jtopl_cpuif #(.DEPTH(8), .BANKS(1), .PACE(1)) u_dut_p1 (
        .clk(clk), .rst(rst), .cenop(cenop), .din(din), .addr(addr),
        .cs_n(cs_n), .wr_n(wr_n), .irq_n(irq_n), .flag_A(flag_A), .flag_B(flag_B),
        .dout(dout_p1), .busy(busy_p1), .ovf(ovf_p1), .reg_we(reg_we_p1),
        .reg_bank(reg_bank_p1), .reg_addr(reg_addr_p1), .reg_din(reg_din_p1)
    );

    always #5 clk = ~clk;

    // cenop changes on the falling edge: 0 = off, N = one pulse every N clocks.
    always @(negedge clk) begin
        if (cen_div == 0) begin
            cenop = 1'b0;
            cen_cnt = 0;
        end else begin
            cen_cnt++;
            if (cen_cnt >= cen_div) begin
                cen_cnt = 0;
                cenop = 1'b1;
            end else begin
                cenop = 1'b0;
            end
        end
    end

    // A write is taken by the consumer at each rising edge with cenop and reg_we high.
    always @(negedge clk) begin
        #1;
        if (cenop === 1'b1) begin
            tick++;
            if (reg_we === 1'b1) begin
                obs_q.push_back({reg_bank, reg_addr, reg_din});
                obs_t.push_back(tick);
            end
            if (reg_we_p1 === 1'b1) begin
                obs_p1_q.push_back({reg_bank_p1, reg_addr_p1, reg_din_p1});
                obs_p1_t.push_back(tick);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        obs_t.delete();
        obs_p1_q.delete();
        obs_p1_t.delete();
    endtask

    // Returns just after the rising edge that sees the strobe.
    task automatic host_write(input logic [1:0] a, input logic [7:0] d, input int hold);
        @(posedge clk);
        @(negedge clk);
        addr = a;
        din  = d;
        cs_n = 1'b0;
        wr_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        cs_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic test_reset();
        cen_div = 0;
        do_reset();
        n_tests++; if (reg_we !== 1'b0)     begin n_fail++; $display("FAIL reset_reg_we got %b want 0", reg_we); end
        n_tests++; if (reg_bank !== 1'b0)   begin n_fail++; $display("FAIL reset_reg_bank got %b want 0", reg_bank); end
        n_tests++; if (reg_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
        n_tests++; if (reg_din !== 8'h00)   begin n_fail++; $display("FAIL reset_reg_din got %h want 00", reg_din); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (ovf !== 1'b0)        begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_tests++; if (dout !== 8'hC6)      begin n_fail++; $display("FAIL reset_dout got %h want c6", dout); end
        irq_n = 1'b1; flag_A = 1'b0; flag_B = 1'b1;
        #1;
        n_tests++; if (dout !== 8'h26)      begin n_fail++; $display("FAIL status_dout got %h want 26", dout); end
        irq_n = 1'b0; flag_A = 1'b1; flag_B = 1'b0;
    endtask

    task automatic test_basic_busy();
        int n;
        logic c;
        cen_div = 4;
        do_reset();
        host_write(2'b00, 8'h20, 1);
        host_write(2'b01, 8'h01, 1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_data got %b want 1", busy); end
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            c = cenop;
            @(posedge clk);
            #1;
            if (c) n++;
            if (!busy) break;
        end
        n_tests++; if (n !== 84) begin n_fail++; $display("FAIL busy_ticks got %0d want 84", n); end
        n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            n_tests++; if (obs_q[0] !== {1'b0, 8'h20, 8'h01}) begin n_fail++; $display("FAIL basic_entry got %h want %h", obs_q[0], {1'b0, 8'h20, 8'h01}); end
        end
    endtask

    task automatic test_held_strobe();
        cen_div = 4;
        do_reset();
        host_write(2'b01, 8'h5A, 1);
        host_write(2'b00, 8'h33, 1);
        host_write(2'b01, 8'h44, 50);
        repeat (100) @(posedge clk);
        n_tests++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL held_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            n_tests++; if (obs_q[0] !== {1'b0, 8'h00, 8'h5A}) begin n_fail++; $display("FAIL no_addr_entry got %h want %h", obs_q[0], {1'b0, 8'h00, 8'h5A}); end
            n_tests++; if (obs_q[1] !== {1'b0, 8'h33, 8'h44}) begin n_fail++; $display("FAIL held_entry got %h want %h", obs_q[1], {1'b0, 8'h33, 8'h44}); end
        end
    endtask

    task automatic test_overflow();
        cen_div = 0;
        do_reset();
        host_write(2'b00, 8'hA0, 1);
        for (int i = 0; i < 4; i++) host_write(2'b01, 8'(i), 1);
        #2;
        n_tests++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL ovf_at_full got %b want 0", ovf); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_full got %b want 1", busy); end
        for (int i = 4; i < 6; i++) host_write(2'b01, 8'(i), 1);
        #2;
        n_tests++; if (ovf !== 1'b1)  begin n_fail++; $display("FAIL ovf_after_drop got %b want 1", ovf); end
        cen_div = 4;
        repeat (80) @(posedge clk);
        n_tests++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== {1'b0, 8'hA0, 8'(i)}) begin n_fail++; $display("FAIL ovf_entry%0d got %h want %h", i, obs_q[i], {1'b0, 8'hA0, 8'(i)}); end
            if (i > 0) begin
                n_tests++; if (obs_t[i] - obs_t[i-1] !== 2) begin n_fail++; $display("FAIL pace_gap%0d got %0d want 2", i, obs_t[i] - obs_t[i-1]); end
            end
        end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    endtask

    task automatic test_bank();
        cen_div = 4;
        do_reset();
        host_write(2'b10, 8'h05, 1);
        host_write(2'b11, 8'h7F, 1);
        host_write(2'b01, 8'h80, 1);
        repeat (60) @(posedge clk);
        n_tests++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL bank_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            n_tests++; if (obs_q[0] !== {1'b1, 8'h05, 8'h7F}) begin n_fail++; $display("FAIL bank_entry0 got %h want %h", obs_q[0], {1'b1, 8'h05, 8'h7F}); end
            n_tests++; if (obs_q[1] !== {1'b1, 8'h05, 8'h80}) begin n_fail++; $display("FAIL bank_entry1 got %h want %h", obs_q[1], {1'b1, 8'h05, 8'h80}); end
        end
        n_tests++; if (obs_p1_q.size() !== 2) begin n_fail++; $display("FAIL onebank_count got %0d want 2", obs_p1_q.size()); end
        if (obs_p1_q.size() == 2) begin
            n_tests++; if (obs_p1_q[0] !== {1'b0, 8'h05, 8'h7F}) begin n_fail++; $display("FAIL onebank_entry got %h want %h", obs_p1_q[0], {1'b0, 8'h05, 8'h7F}); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        cen_div = 0;
        do_reset();
        host_write(2'b00, 8'h11, 1);
        for (int i = 1; i <= 5; i++) host_write(2'b01, 8'(i), 1);
        #2;
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL mid_ovf_set got %b want 1", ovf); end
        cen_div = 1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (reg_we) begin seen = 1'b1; break; end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_first_we got 0 want 1"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL mid_reg_we got %b want 0", reg_we); end
        n_tests++; if (ovf !== 1'b0)    begin n_fail++; $display("FAIL mid_ovf got %b want 0", ovf); end
        n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        obs_t.delete();
        repeat (50) @(posedge clk);
        n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL mid_after_count got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_pace1();
        cen_div = 0;
        do_reset();
        host_write(2'b00, 8'h42, 1);
        for (int i = 0; i < 3; i++) host_write(2'b01, 8'h10 + 8'(i), 1);
        cen_div = 1;
        repeat (20) @(posedge clk);
        n_tests++; if (obs_p1_q.size() !== 3) begin n_fail++; $display("FAIL pace1_count got %0d want 3", obs_p1_q.size()); end
        for (int i = 0; i < 3 && i < obs_p1_q.size(); i++) begin
            n_tests++; if (obs_p1_q[i] !== {1'b0, 8'h42, 8'h10 + 8'(i)}) begin n_fail++; $display("FAIL pace1_entry%0d got %h want %h", i, obs_p1_q[i], {1'b0, 8'h42, 8'h10 + 8'(i)}); end
            if (i > 0) begin
                n_tests++; if (obs_p1_t[i] - obs_p1_t[i-1] !== 1) begin n_fail++; $display("FAIL pace1_gap%0d got %0d want 1", i, obs_p1_t[i] - obs_p1_t[i-1]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_busy();
        test_held_strobe();
        test_overflow();
        test_bank();
        test_reset_mid();
        test_pace1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
